decode: RTL and testbench

Instruction-decode stage of the 16-bit-instruction audio DSP core. Holds the NUMREGISTERS×DATAW general register file and reads two source operands from it. Extracts the immediate and shift fields and generates all per-instruction control strobes for execute, memory, FFT and synth stages. Writeback arrives from the end of the pipeline through the wr_* inputs.

---
 rtl/decode.sv | 138 +++++++++++++
 tb/tb_decode.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// Decode stage: register file, field extraction and control strobes.
// Optional write-through forwarding selected by macro DECODE_BYPASS_EN.
module decode #(
    parameter int NUMREGISTERS = 8,
    parameter int DATAW        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      instr,
    input  logic             reg_wr_en_in,
    input  logic [2:0]       wr_reg,
    input  logic [DATAW-1:0] wr_data,
    output logic [DATAW-1:0] a,
    output logic [DATAW-1:0] b,
    output logic [10:0]      imm,
    output logic [1:0]       shift_dist,
    output logic             halt,
    output logic             alu_op,
    output logic             reg_wr_en_out,
    output logic             mem_wr_en,
    output logic             branch,
    output logic             fft_wr_en,
    output logic             set_en,
    output logic             syn,
    output logic             use_imm,
    output logic             set_freq
);

    localparam logic [4:0] OP_HALT = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_ADDI = 5'b00100;
    localparam logic [4:0] OP_ST   = 5'b00101;
    localparam logic [4:0] OP_BR   = 5'b00110;
    localparam logic [4:0] OP_FFT  = 5'b00111;
    localparam logic [4:0] OP_SET  = 5'b01000;
    localparam logic [4:0] OP_SYN  = 5'b01001;
    localparam logic [4:0] OP_FREQ = 5'b01010;

    // rst_n is active-high despite its name
    logic [DATAW-1:0] regs [NUMREGISTERS];
    logic [4:0]       opcode;
    logic [2:0]       rs;
    logic [2:0]       rt;
    logic [DATAW-1:0] rd_a;
    logic [DATAW-1:0] rd_b;

    assign opcode = instr[15:11];
    assign rs     = instr[7:5];
    assign rt     = instr[4:2];

    // Register file: cleared asynchronously, one write port
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NUMREGISTERS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_wr_en_in) begin
            regs[wr_reg] <= wr_data;
        end
    end

`ifdef DECODE_BYPASS_EN
    // Forward writeback data to a matching read index in the same cycle
    always_comb begin
        rd_a = regs[rs];
        rd_b = regs[rt];
        if (reg_wr_en_in && (wr_reg == rs)) begin
            rd_a = wr_data;
        end
        if (reg_wr_en_in && (wr_reg == rt)) begin
            rd_b = wr_data;
        end
    end
`else
    // Reads see the stored value; a same-cycle write lands after the edge
    always_comb begin
        rd_a = regs[rs];
        rd_b = regs[rt];
    end
`endif

    // Operand/field outputs and opcode strobes, all held low in reset
    always_comb begin
        a             = '0;
        b             = '0;
        imm           = '0;
        shift_dist    = '0;
        halt          = 1'b0;
        alu_op        = 1'b0;
        reg_wr_en_out = 1'b0;
        mem_wr_en     = 1'b0;
        branch        = 1'b0;
        fft_wr_en     = 1'b0;
        set_en        = 1'b0;
        syn           = 1'b0;
        use_imm       = 1'b0;
        set_freq      = 1'b0;
        if (!rst_n) begin
            a   = rd_a;
            b   = rd_b;
            imm = instr[10:0];
            unique case (opcode)
                OP_HALT: halt = 1'b1;
                OP_ADD: begin
                    reg_wr_en_out = 1'b1;
                    shift_dist    = instr[1:0];
                end
                OP_SUB: begin
                    reg_wr_en_out = 1'b1;
                    alu_op        = 1'b1;
                    shift_dist    = instr[1:0];
                end
                OP_ADDI: begin
                    reg_wr_en_out = 1'b1;
                    use_imm       = 1'b1;
                end
                OP_ST: begin
                    mem_wr_en = 1'b1;
                    use_imm   = 1'b1;
                end
                OP_BR: begin
                    branch  = 1'b1;
                    use_imm = 1'b1;
                end
                OP_FFT:  fft_wr_en = 1'b1;
                OP_SET:  set_en    = 1'b1;
                OP_SYN:  syn       = 1'b1;
                OP_FREQ: begin
                    set_freq = 1'b1;
                    use_imm  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decode.sv
// Randomized self-checking bench for decode against a table-driven model.
// Honours DECODE_BYPASS_EN when computing expected operands.
module tb_decode;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        reg_wr_en_in;
    logic [2:0]  wr_reg;
    logic [31:0] wr_data;
    logic [31:0] a;
    logic [31:0] b;
    logic [10:0] imm;
    logic [1:0]  shift_dist;
    logic        halt, alu_op, reg_wr_en_out, mem_wr_en, branch;
    logic        fft_wr_en, set_en, syn, use_imm, set_freq;
    logic [9:0]  strobes;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [8];
    logic [9:0]  strobe_tab [32];

    decode #(.NUMREGISTERS(8), .DATAW(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .reg_wr_en_in(reg_wr_en_in), .wr_reg(wr_reg), .wr_data(wr_data),
        .a(a), .b(b), .imm(imm), .shift_dist(shift_dist),
        .halt(halt), .alu_op(alu_op), .reg_wr_en_out(reg_wr_en_out),
        .mem_wr_en(mem_wr_en), .branch(branch), .fft_wr_en(fft_wr_en),
        .set_en(set_en), .syn(syn), .use_imm(use_imm), .set_freq(set_freq)
    );

    assign strobes = {halt, alu_op, reg_wr_en_out, mem_wr_en, branch,
                      fft_wr_en, set_en, syn, use_imm, set_freq};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [2:0] idx);
        logic [31:0] v;
        v = model[idx];
`ifdef DECODE_BYPASS_EN
        if (reg_wr_en_in && wr_reg == idx) v = wr_data;
`endif
        return v;
    endfunction

    task automatic compare_all(input string tag);
        logic [4:0] op;
        op = instr[15:11];
        if (rst_n) begin
            check({tag, ".a"}, a, 0);
            check({tag, ".b"}, b, 0);
            check({tag, ".imm"}, imm, 0);
            check({tag, ".shift"}, shift_dist, 0);
            check({tag, ".strobes"}, strobes, 0);
        end else begin
            check({tag, ".a"}, a, exp_read(instr[7:5]));
            check({tag, ".b"}, b, exp_read(instr[4:2]));
            check({tag, ".imm"}, imm, instr[10:0]);
            check({tag, ".shift"}, shift_dist,
                  (op == 5'd2 || op == 5'd3) ? instr[1:0] : 2'd0);
            check({tag, ".strobes"}, strobes, strobe_tab[op]);
        end
    endtask

    task automatic step(input string tag, input logic [15:0] i,
                        input logic we, input logic [2:0] wr,
                        input logic [31:0] wd, input logic r);
        @(negedge clk);
        instr        = i;
        reg_wr_en_in = we;
        wr_reg       = wr;
        wr_data      = wd;
        rst_n        = r;
        if (r) foreach (model[k]) model[k] = 0;
        #2;
        compare_all(tag);
        @(posedge clk);
        if (we && !r) model[wr] = wd;
    endtask

    initial begin
        foreach (strobe_tab[k]) strobe_tab[k] = 10'h000;
        strobe_tab[1]  = 10'h200;
        strobe_tab[2]  = 10'h080;
        strobe_tab[3]  = 10'h180;
        strobe_tab[4]  = 10'h082;
        strobe_tab[5]  = 10'h042;
        strobe_tab[6]  = 10'h022;
        strobe_tab[7]  = 10'h010;
        strobe_tab[8]  = 10'h008;
        strobe_tab[9]  = 10'h004;
        strobe_tab[10] = 10'h003;
        foreach (model[k]) model[k] = 32'hx;

        instr = 16'h1234; reg_wr_en_in = 1'b1; wr_reg = 3'd1;
        wr_data = 32'h5555_5555; rst_n = 1'b1;

        step("rst", 16'h1234, 1'b1, 3'd2, 32'h1111, 1'b1);
        step("rst2", 16'h1234, 1'b0, 3'd0, 32'h0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] ix;
            ix = 3'(i);
            step("rd0", {5'b0, 3'd0, ix, ix, 2'b0}, 1'b0, 3'd0, 0, 1'b0);
            check("rd0.zero", a, 0);
        end

        step("wr3", 16'h0, 1'b1, 3'd3, 32'hDEADBEEF, 1'b0);
        step("add3", {5'b00010, 3'd0, 3'd3, 3'd3, 2'b10},
             1'b0, 3'd0, 0, 1'b0);
        check("add3.a_const", a, 32'hDEADBEEF);
        check("add3.b_const", b, 32'hDEADBEEF);
        check("add3.shift_const", shift_dist, 2);

        for (int op = 0; op <= 10; op++) begin
            logic [4:0] o;
            o = 5'(op);
            step("sweep", {o, 11'h5A5}, 1'b0, 3'd0, 0, 1'b0);
        end
        step("op31", {5'b11111, 11'h5A5}, 1'b0, 3'd0, 0, 1'b0);
        check("op31.strobes_const", strobes, 0);

        step("pre5", 16'h0, 1'b1, 3'd5, 32'h0000_0011, 1'b0);
        step("byp5", {5'b00010, 3'd0, 3'd5, 3'd0, 2'b0},
             1'b1, 3'd5, 32'h0000_00AB, 1'b0);
`ifdef DECODE_BYPASS_EN
        check("byp5.a_const", a, 32'hAB);
`else
        check("byp5.a_const", a, 32'h11);
`endif
        step("post5", {5'b00010, 3'd0, 3'd5, 3'd0, 2'b0},
             1'b0, 3'd0, 0, 1'b0);
        check("post5.a_const", a, 32'hAB);

        for (int n = 0; n < 400; n++) begin
            logic [15:0] ri;
            logic        rr;
            ri = 16'($urandom);
            if ($urandom_range(0, 3) != 0)
                ri[15:11] = 5'($urandom_range(0, 11));
            rr = ($urandom_range(0, 24) == 0);
            step("rand", ri, 1'($urandom), 3'($urandom),
                 $urandom, rr);
        end

        step("wr7", 16'h0, 1'b1, 3'd7, 32'h1, 1'b0);
        @(negedge clk);
        instr = {5'b00010, 3'd0, 3'd7, 3'd7, 2'b0};
        reg_wr_en_in = 1'b1; wr_reg = 3'd7; wr_data = 32'h55;
        #1;
        compare_all("mid.pre");
        rst_n = 1'b1;
        foreach (model[k]) model[k] = 0;
        #1;
        check("mid.a_async", a, 0);
        compare_all("mid.rst");
        @(posedge clk);
        step("mid.rel", {5'b00010, 3'd0, 3'd7, 3'd7, 2'b0},
             1'b0, 3'd0, 0, 1'b0);
        check("mid.r7_zero", a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
